// File: rtl/adder_pkg.sv
// adder_pkg: shared helpers for the carry-segmented pipelined adder.
//   seg_width      - width of every segment except the last (ceil(width/stages))
//   last_seg_width - width left over for the final segment
//   clog2          - ceiling log2 helper
//   params_ok      - legal parameter range check, evaluated at elaboration
package adder_pkg;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 1024;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int seg_width(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int last_seg_width(input int width, input int stages);
    return width - (stages - 1) * seg_width(width, stages);
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
           (stages >= 1) && (stages <= width) &&
           (last_seg_width(width, stages) >= 1);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// adder_segment: one W-bit carry-chain slice with registered sum and carry-out.
// Ports:
//   clk    - rising-edge clock
//   i_clr  - synchronous clear of the registered outputs (used only where the
//            slice drives the block output directly)
//   i_en   - load enable (pipeline advance)
//   i_a    - operand A slice
//   i_b    - operand B slice (already inverted for subtraction)
//   i_cin  - carry-in from the previous segment
//   o_sum  - registered slice sum
//   o_cout - registered slice carry-out
module adder_segment
  import adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0]   w_full;
  logic [W-1:0] r_sum;
  logic         r_cout;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (i_en) begin
      r_sum  <= w_full[W-1:0];
      r_cout <= w_full[W];
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: rtl/adder_pipelined.sv
// adder_pipelined: WIDTH-bit adder split into STAGES carry segments, one
// pipeline stage per segment, with valid/ready flow control.
// Optional feature macro: ADDER_SUB_EN (adds the sub port; a - b when sub = 1).
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset (valid bits and out_sum)
//   in_valid  - operand pair present
//   in_ready  - operands accepted this cycle (= pipeline advance)
//   a, b      - WIDTH-bit operands
//   sub       - subtract select (only with ADDER_SUB_EN)
//   out_valid - out_sum holds a result
//   out_ready - downstream accepts the result
//   out_sum   - WIDTH+1-bit result, bit WIDTH is the final carry-out
// Latency is STAGES+1 cycles: stage 0 registers operands, stage k (1..STAGES)
// adds segment k-1. Upper operand bits ride skew registers until their
// segment's stage, finished low sum bits ride deskew registers to the output.
module adder_pipelined
  import adder_pkg::*;
#(
  parameter int WIDTH  = 109,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  localparam int SEG  = seg_width(WIDTH, STAGES);
  localparam int LAST = last_seg_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_param_err
    $error("adder_pipelined: illegal WIDTH/STAGES combination");
  end

  logic             w_advance;
  logic [STAGES:0]  r_vld;
  logic [WIDTH-1:0] r_a_p0;
  logic [WIDTH-1:0] r_b_p0;
  logic [STAGES:0]  w_cy;
  logic [WIDTH-1:0] w_sum;

  assign w_advance = !r_vld[STAGES] | out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_vld[STAGES];
  assign out_sum   = {w_cy[STAGES], w_sum};

  // valid shift register: bit k is the valid of stage k
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else if (w_advance) begin
      r_vld <= {r_vld[STAGES-1:0], in_valid};
    end
  end

  // stage 0: operand capture
`ifdef ADDER_SUB_EN
  logic r_sub_p0;
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_a_p0   <= a;
      r_b_p0   <= sub ? ~b : b;
      r_sub_p0 <= sub;
    end
  end
  assign w_cy[0] = r_sub_p0;
`else
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_a_p0 <= a;
      r_b_p0 <= b;
    end
  end
  assign w_cy[0] = 1'b0;
`endif

  // stages 1..STAGES: segment j is added in stage j+1
  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    localparam int WJ   = (j == STAGES - 1) ? LAST : SEG;
    localparam int LO   = j * SEG;
    localparam int NDSK = STAGES - 1 - j;

    logic [WJ-1:0] w_a_seg;
    logic [WJ-1:0] w_b_seg;
    logic [WJ-1:0] w_seg_sum;

    if (j == 0) begin : g_noskew
      assign w_a_seg = r_a_p0[LO +: WJ];
      assign w_b_seg = r_b_p0[LO +: WJ];
    end else begin : g_skew
      logic [WJ-1:0] r_a_dly [j];
      logic [WJ-1:0] r_b_dly [j];
      always_ff @(posedge clk) begin
        if (w_advance) begin
          r_a_dly[0] <= r_a_p0[LO +: WJ];
          r_b_dly[0] <= r_b_p0[LO +: WJ];
          for (int d = 1; d < j; d++) begin
            r_a_dly[d] <= r_a_dly[d-1];
            r_b_dly[d] <= r_b_dly[d-1];
          end
        end
      end
      assign w_a_seg = r_a_dly[j-1];
      assign w_b_seg = r_b_dly[j-1];
    end

    adder_segment #(.W(WJ)) u_seg (
      .clk    (clk),
      .i_clr  ((NDSK == 0) && reset),
      .i_en   (w_advance),
      .i_a    (w_a_seg),
      .i_b    (w_b_seg),
      .i_cin  (w_cy[j]),
      .o_sum  (w_seg_sum),
      .o_cout (w_cy[j+1])
    );

    if (NDSK == 0) begin : g_nodsk
      assign w_sum[LO +: WJ] = w_seg_sum;
    end else begin : g_dsk
      logic [WJ-1:0] w_dsk_in;
      logic [WJ-1:0] r_dsk_out;
      if (NDSK > 1) begin : g_chain
        logic [WJ-1:0] r_dsk [NDSK-1];
        always_ff @(posedge clk) begin
          if (w_advance) begin
            r_dsk[0] <= w_seg_sum;
            for (int d = 1; d < NDSK - 1; d++) begin
              r_dsk[d] <= r_dsk[d-1];
            end
          end
        end
        assign w_dsk_in = r_dsk[NDSK-2];
      end else begin : g_direct
        assign w_dsk_in = w_seg_sum;
      end
      // output-row register is part of out_sum, so it clears on reset
      always_ff @(posedge clk) begin
        if (reset) begin
          r_dsk_out <= '0;
        end else if (w_advance) begin
          r_dsk_out <= w_dsk_in;
        end
      end
      assign w_sum[LO +: WJ] = r_dsk_out;
    end
  end

endmodule

// File: tb/tb_adder_pipelined.sv
module tb_adder_pipelined;

  localparam int WIDTH  = 109;
  localparam int STAGES = 4;
  localparam int RW     = WIDTH + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;

  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_a;
  logic [7:0] s_b;
  logic       s_out_valid;
  logic [8:0] s_out_sum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH:0] q_exp [$];
  logic [WIDTH:0] mon_exp;

  adder_pipelined #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  adder_pipelined #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .a         (s_a),
    .b         (s_b),
`ifdef ADDER_SUB_EN
    .sub       (1'b0),
`endif
    .out_valid (s_out_valid),
    .out_ready (1'b1),
    .out_sum   (s_out_sum)
  );

  task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s);
    if (s) return {1'b1, x} - {1'b0, y};
    return {1'b0, x} + {1'b0, y};
  endfunction

  // scoreboard: push on accept, pop/compare on present
  always @(negedge clk) begin
    if (reset) begin
      q_exp.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          check("stray_result", RW'(out_valid), RW'(0));
        end else begin
          mon_exp = q_exp.pop_front();
          check("result", out_sum, mon_exp);
        end
      end
      if (in_valid && in_ready) q_exp.push_back(model(a, b, sub));
    end
  end

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    bit acc = 1'b0;
    a = x; b = y; sub = s; in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", RW'(in_ready), RW'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q_exp.size() != 0; k++) @(posedge clk);
    #1;
    check("drain", RW'(q_exp.size()), RW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH:0]   one_hi;
    logic [WIDTH:0]   held;
    logic [WIDTH-1:0] x;
    logic [127:0]     t;
    int               lat;
    int               nv;
    int               first;
    int               last;
    bit               acc;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    s_valid = 1'b0; s_a = '0; s_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", RW'(out_valid), RW'(0));
    check("rst_out_sum", out_sum, RW'(0));
    check("rst_in_ready", RW'(in_ready), RW'(1));
    check("rst_s_out_valid", RW'(s_out_valid), RW'(0));
    @(posedge clk); #1;

    // all ones + 1, latency
    one_hi = '0; one_hi[WIDTH] = 1'b1;
    a = '1; b = WIDTH'(1); sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", RW'(lat), RW'(5));
    check("ones_plus_one", out_sum, one_hi);
    @(posedge clk); #1;
    drain();

    // back-to-back stream a=i, b=3i
    nv = 0; first = -1; last = -1;
    a = WIDTH'(1); b = WIDTH'(3); in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 8) check("stream_in_ready", RW'(in_ready), RW'(1));
      if (out_valid) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk); #1;
      if (c + 1 < 8) begin
        a = WIDTH'(c + 2); b = WIDTH'(3 * (c + 2));
      end else begin
        in_valid = 1'b0;
      end
    end
    check("stream_count", RW'(nv), RW'(8));
    check("stream_span", RW'(last - first + 1), RW'(8));
    drain();

    // carries across every segment boundary, plus random pairs
    for (int bd = 28; bd <= 84; bd += 28) begin
      x = (WIDTH'(1) << bd) - WIDTH'(1);
      send(x, WIDTH'(1), 1'b0);
    end
    send('1, '1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      x = t[WIDTH-1:0];
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(x, t[WIDTH-1:0], 1'b0);
    end
    drain();

    // stall with a full pipeline, one operand pair waiting
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(WIDTH'(100 + i), WIDTH'(7 * i), 1'b0);
    a = WIDTH'(555); b = WIDTH'(444); in_valid = 1'b1;
    @(negedge clk);
    held = out_sum;
    check("stall_first", held, RW'(100));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_in_ready", RW'(in_ready), RW'(0));
      check("stall_out_valid", RW'(out_valid), RW'(1));
      check("stall_hold", out_sum, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("release_accept", RW'(acc), RW'(1));
    drain();

    // reset with three operations in flight; in_valid held during reset
    send(WIDTH'(11), WIDTH'(22), 1'b0);
    send(WIDTH'(33), WIDTH'(44), 1'b0);
    send(WIDTH'(55), WIDTH'(66), 1'b0);
    a = WIDTH'(77); b = WIDTH'(88); in_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", RW'(out_valid), RW'(0));
    check("midrst_out_sum", out_sum, RW'(0));
    check("midrst_in_ready", RW'(in_ready), RW'(1));
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("midrst_no_stale", RW'(nv), RW'(0));
    @(posedge clk); #1;

`ifdef ADDER_SUB_EN
    send(WIDTH'(0), WIDTH'(1), 1'b1);
    send(WIDTH'(5), WIDTH'(3), 1'b1);
    send(WIDTH'(3), WIDTH'(5), 1'b1);
    send(WIDTH'(9), WIDTH'(9), 1'b1);
    drain();
`endif

    // single-stage instance: 5 + 7 after 2 cycles
    s_a = 8'd5; s_b = 8'd7; s_valid = 1'b1;
    @(negedge clk);
    check("s_in_ready", RW'(s_ready), RW'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (s_out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    check("s_latency", RW'(lat), RW'(2));
    check("s_sum", RW'(s_out_sum), RW'(12));
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
